key_event_arbiter: RTL and testbench
====================================

// Module: key_event_arbiter
// PURPOSE
//   Collects debounced press pulses and held levels from NUM_KEYS key debouncers.
//   Classifies each press as PRESS, LONG or REPEAT.
//   Shares one event channel between all keys using round-robin arbitration.
//   Delivers events to the data-loop control logic over a valid/ready handshake.
// PARAMETERS
//   NUM_KEYS    4           number of debounced key inputs (>=2)
//   LONG_CYC    50_000_000  held cycles after the press pulse before the LONG event (>=2)
//   REPEAT_CYC  10_000_000  cycles between REPEAT events while held after LONG (>=2)
//   CNT_W       32          hold/repeat counter width; must hold max(LONG_CYC,REPEAT_CYC)
// PORTS
//   clk          in   1                 system clock
//   rst_n        in   1                 asynchronous active-low reset
//   key_flag     in   NUM_KEYS          1-cycle press pulse per key, from the debouncer
//   key_pressed  in   NUM_KEYS          debounced level per key, 1 = still held
//   evt_valid    out  1                 event available
//   evt_ready    in   1                 consumer accepts the event when valid&&ready
//   evt_key      out  $clog2(NUM_KEYS)  index of the key that raised the event
//   evt_type     out  2                 01 PRESS, 10 LONG, 11 REPEAT (00 never when valid)
//   drop_cnt     out  8                 pending events overwritten before grant; saturates at 255
// BEHAVIOUR
//   Reset: async assert; all outputs, pend bits, counters and rr_ptr = 0; key FSMs -> K_IDLE.
//   Per-key FSM (hold_cnt is per key, CNT_W bits):
//     K_IDLE : key_flag=1 -> raise PRESS, hold_cnt<=0, go K_PRESS.
//     K_PRESS: key_pressed=0 -> K_IDLE.
//              else if hold_cnt==LONG_CYC-1 -> raise LONG, hold_cnt<=0, go K_LONG.
//              else hold_cnt++.
//     K_LONG : key_pressed=0 -> K_IDLE.
//              else if hold_cnt==REPEAT_CYC-1 -> raise REPEAT, hold_cnt<=0.
//              else hold_cnt++.
//     key_flag outside K_IDLE is ignored.
//     Release on the threshold cycle: release wins; no event is raised.
//   Raise: sets pend[k] and pend_type[k].
//     If pend[k] is already set and is not granted this cycle: overwrite the type
//     with the newer event and increment drop_cnt (saturating).
//     If pend[k] is granted in the same cycle: the new event stays pending; no drop counted.
//   Arbiter: the output slot may load when !evt_valid or (evt_valid && evt_ready).
//     Grant = first k with pend[k]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping at NUM_KEYS.
//     On grant: load evt_key/evt_type, evt_valid<=1, clear pend[grant],
//     rr_ptr <= grant+1 (wraps to 0).
//     If the slot is consumed and nothing is pending: evt_valid<=0.
//   Handshake: evt_key and evt_type are stable while evt_valid && !evt_ready.
//     evt_valid never drops without acceptance. Throughput is 1 event/cycle.
//   Latency: key_flag sampled at edge N -> pend set at N; evt_valid high after edge N+1
//     (slot free). The first LONG is raised LONG_CYC+1 edges after the key_flag edge.
//   Reset mid-operation discards all pending and in-flight events without handshake.
// STRUCTURE
//   Package key_evt_pkg: EVT_PRESS=2'b01, EVT_LONG=2'b10, EVT_REPEAT=2'b11;
//     key FSM state encodings K_IDLE/K_PRESS/K_LONG.
//   Sub-module key_hold_fsm: one instance per key via generate.
//     Holds FSM state and hold_cnt; outputs raise and raise_type.
//   Top level: pend registers, drop counter, round-robin arbiter, output slot.
// TESTING (LONG_CYC=20, REPEAT_CYC=8, NUM_KEYS=4)
//   1. key_flag[2] pulse, key_pressed[2] dropped 3 cycles later, evt_ready=1
//      -> one event key=2 type=01; evt_valid high exactly 1 cycle.
//   2. Hold key 1 for 40 cycles after the pulse
//      -> PRESS, then LONG at edge +21, then REPEAT every 8 cycles until release.
//   3. key_flag[0..3] pulsed in the same cycle, rr_ptr=2
//      -> grant order 2,3,0,1 on consecutive cycles; rr_ptr=2 after.
//   4. evt_ready=0 for 30 cycles while key 0 is held to LONG
//      -> output holds PRESS, pend[0] type=LONG, drop_cnt=0; REPEAT overwrite -> drop_cnt=1.
//   5. Release on the exact LONG threshold cycle -> no LONG; FSM back to K_IDLE.
//   6. Assert rst_n=0 while evt_valid=1 with pends set
//      -> evt_valid=0 and drop_cnt=0 immediately; no events after release.

Source files
------------

// File: rtl/key_event_arbiter_pkg.sv
// key_evt_pkg: shared event codes and per-key FSM state encoding
package key_evt_pkg;
  localparam logic [1:0] EVT_PRESS = 2'b01;
  localparam logic [1:0] EVT_LONG = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;
  typedef enum logic [1:0] {K_IDLE = 2'd0, K_PRESS = 2'd1, K_LONG = 2'd2} key_state_t;
endpackage

// File: rtl/key_hold_fsm.sv
// key_hold_fsm: classifies one key's press into PRESS, LONG and REPEAT raises
module key_hold_fsm
  import key_evt_pkg::*;
#(
  parameter int LONG_CYC = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag,
  input  logic       pressed,
  output logic       raise,
  output logic [1:0] raise_type
);
  key_state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= K_IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  end
  // release always beats a threshold hit in the same cycle
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    raise = 1'b0;
    raise_type = EVT_PRESS;
    case (state)
      K_IDLE: if (flag) begin
        raise = 1'b1;
        cnt_nxt = '0;
        nxt = K_PRESS;
      end
      K_PRESS: if (!pressed) nxt = K_IDLE;
        else if (cnt == CNT_W'(LONG_CYC - 1)) begin
          raise = 1'b1;
          raise_type = EVT_LONG;
          cnt_nxt = '0;
          nxt = K_LONG;
        end else cnt_nxt = cnt + CNT_W'(1);
      K_LONG: if (!pressed) nxt = K_IDLE;
        else if (cnt == CNT_W'(REPEAT_CYC - 1)) begin
          raise = 1'b1;
          raise_type = EVT_REPEAT;
          cnt_nxt = '0;
        end else cnt_nxt = cnt + CNT_W'(1);
      default: nxt = K_IDLE;
    endcase
  end
endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: per-key press classification shared over one round-robin valid/ready channel
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int LONG_CYC = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W = 32,
  localparam int KW = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_pressed,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_type,
  output logic [7:0]          drop_cnt
);
  logic [NUM_KEYS-1:0] raise, pend, clr, drop;
  logic [1:0] raise_type [NUM_KEYS];
  logic [1:0] pend_type [NUM_KEYS];
  logic [KW-1:0] rr_ptr, gnt;
  logic gnt_vld, load;
  logic [7:0] n_drop, drop_nxt;
  logic [8:0] drop_sum;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_hold_fsm #(.LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(CNT_W)) u_fsm (
      .clk(clk), .rst_n(rst_n), .flag(key_flag[k]), .pressed(key_pressed[k]),
      .raise(raise[k]), .raise_type(raise_type[k])
    );
    assign clr[k] = load && gnt_vld && gnt == KW'(k);
    assign drop[k] = raise[k] && pend[k] && !clr[k];
  end
  assign load = !evt_valid || evt_ready;
  // scan downwards so the entry closest to rr_ptr is the last one written
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (pend[(int'(rr_ptr) + i) % NUM_KEYS]) begin
        gnt_vld = 1'b1;
        gnt = KW'((int'(rr_ptr) + i) % NUM_KEYS);
      end
  end
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_KEYS; i++) n_drop = n_drop + 8'(drop[i]);
    drop_sum = {1'b0, drop_cnt} + {1'b0, n_drop};
    drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_key <= '0;
      evt_type <= '0;
      rr_ptr <= '0;
      drop_cnt <= '0;
      pend <= '0;
      for (int i = 0; i < NUM_KEYS; i++) pend_type[i] <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (load) begin
        evt_valid <= gnt_vld;
        if (gnt_vld) begin
          evt_key <= gnt;
          evt_type <= pend_type[gnt];
          rr_ptr <= (gnt == KW'(NUM_KEYS - 1)) ? '0 : gnt + KW'(1);
        end
      end
      for (int i = 0; i < NUM_KEYS; i++)
        if (raise[i]) begin
          pend[i] <= 1'b1;
          pend_type[i] <= raise_type[i];
        end else if (clr[i]) pend[i] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed and random stimulus against a hold-age event model
module tb_key_event_arbiter;
  import key_evt_pkg::*;
  localparam int N = 4, L = 20, R = 8;
  logic clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b0;
  logic [N-1:0] key_flag = '0, key_pressed = '0;
  logic evt_valid;
  logic [1:0] evt_key, evt_type;
  logic [7:0] drop_cnt;
  int checks = 0, failures = 0, vcnt;
  int m_age[N], m_ptype[N];
  bit m_pend[N], m_valid;
  int m_key, m_type, m_rr, m_drop;
  int order[4] = '{2, 3, 0, 1};

  key_event_arbiter #(.NUM_KEYS(N), .LONG_CYC(L), .REPEAT_CYC(R), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .key_flag(key_flag), .key_pressed(key_pressed),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_age[k] = -1;
      m_pend[k] = 0;
      m_ptype[k] = 0;
    end
    m_valid = 0; m_key = 0; m_type = 0; m_rr = 0; m_drop = 0;
  endtask

  // age counts edges since the press pulse; events fall at fixed ages while held
  task automatic model_step();
    int r[N];
    int g;
    bit load;
    load = !m_valid || evt_ready;
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && m_pend[(m_rr + i) % N]) g = (m_rr + i) % N;
    for (int k = 0; k < N; k++) begin
      r[k] = 0;
      if (m_age[k] < 0) begin
        if (key_flag[k]) begin r[k] = 1; m_age[k] = 0; end
      end else if (!key_pressed[k]) m_age[k] = -1;
      else begin
        m_age[k]++;
        if (m_age[k] == L) r[k] = 2;
        else if (m_age[k] > L && (m_age[k] - L) % R == 0) r[k] = 3;
      end
    end
    if (load) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_key = g;
        m_type = m_ptype[g];
        m_rr = (g + 1) % N;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (r[k] != 0) begin
        if (m_pend[k] && !(load && g == k)) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        m_pend[k] = 1;
        m_ptype[k] = r[k];
      end else if (load && g == k) m_pend[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    chk("valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) begin
      chk("key", 32'(evt_key), m_key);
      chk("type", 32'(evt_type), m_type);
    end
    chk("drop", 32'(drop_cnt), m_drop);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_key", 32'(evt_key), 0);
    chk("rst_type", 32'(evt_type), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    // short press on key 2
    evt_ready = 1'b1;
    key_flag[2] = 1'b1;
    key_pressed[2] = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vcnt += int'(evt_valid);
      if (i == 0) key_flag = '0;
      if (i == 2) key_pressed[2] = 1'b0;
    end
    chk("t1_valid_cycles", vcnt, 1);
    // long hold on key 1
    key_flag[1] = 1'b1;
    key_pressed[1] = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      tick();
      if (i == 0) key_flag = '0;
      if (i == 21) chk("t2_long", 32'(evt_type), 32'(EVT_LONG));
      if (i == 29) chk("t2_repeat", 32'(evt_type), 32'(EVT_REPEAT));
    end
    key_pressed = '0;
    repeat (5) tick();
    // simultaneous presses with the pointer sitting at 2
    key_flag = '1;
    tick();
    key_flag = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_valid", 32'(evt_valid), 1);
      chk("t3_key", 32'(evt_key), order[i]);
    end
    repeat (3) tick();
    // stalled consumer while key 0 climbs to LONG then REPEAT
    evt_ready = 1'b0;
    key_flag[0] = 1'b1;
    key_pressed[0] = 1'b1;
    tick();
    key_flag = '0;
    repeat (24) tick();
    chk("t4_drop_long", 32'(drop_cnt), 0);
    repeat (6) tick();
    chk("t4_hold_type", 32'(evt_type), 32'(EVT_PRESS));
    chk("t4_hold_key", 32'(evt_key), 0);
    chk("t4_drop_repeat", 32'(drop_cnt), 1);
    key_pressed = '0;
    evt_ready = 1'b1;
    repeat (5) tick();
    // release lands exactly on the LONG threshold edge
    key_flag[3] = 1'b1;
    key_pressed[3] = 1'b1;
    tick();
    key_flag = '0;
    repeat (19) tick();
    key_pressed[3] = 1'b0;
    vcnt = 0;
    repeat (6) begin
      tick();
      vcnt += int'(evt_valid);
    end
    chk("t5_no_long", vcnt, 0);
    // random traffic
    repeat (1500) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom % 40 == 0) key_pressed[k] = ~key_pressed[k];
        key_flag[k] = ($urandom % 16 == 0);
        if (key_flag[k]) key_pressed[k] = 1'b1;
      end
      evt_ready = ($urandom % 4 != 0);
      tick();
    end
    // reset while the slot is full and events are pending
    evt_ready = 1'b0;
    key_flag = '1;
    key_pressed = '1;
    tick();
    key_flag = '0;
    repeat (3) tick();
    chk("t6_pre_valid", 32'(evt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", 32'(evt_valid), 0);
    chk("t6_drop", 32'(drop_cnt), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    key_pressed = '0;
    evt_ready = 1'b1;
    vcnt = 0;
    repeat (40) begin
      tick();
      vcnt += int'(evt_valid);
    end
    chk("t6_no_events", vcnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
